// File: rtl/aes_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_pkg
//  Description : Shared AES-128 key-schedule definitions.
//                - AES_BLOCK_SIZE : block/key width, 128 bits.
//                - AES_NR         : number of rounds, 10.
//                - AES_RCON       : round constants rcon[1..10].
//                - ks_state_t     : key-schedule FSM states.
//                - rcon_lookup()  : table lookup, 0 outside 1..10.
//                - sbox()         : forward AES S-box.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_key_pkg;

    // Same value as the shared AES_BLOCK_SIZE define.
    localparam int AES_BLOCK_SIZE = 128;
    localparam int AES_NR         = 10;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        KS_IDLE    = 2'd0,
        KS_PRECOMP = 2'd1,
        KS_OUTPUT  = 2'd2
    } ks_state_t;

    // Byte x lives in bits [2047-8x -: 8]; row 0 of the table is first.
    localparam logic [2047:0] AES_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if ((idx >= 4'd1) && (idx <= 4'd10)) begin
            v = AES_RCON[idx];
        end
        return v;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        // 2047 - 8*b in 11 bits is simply the bitwise complement of 8*b.
        msb = ~{b, 3'b000};
        return AES_SBOX_TABLE[msb -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_step
//  Description : Combinational AES-128 key-expansion step, forward or inverse.
//                One set of four S-boxes is shared between directions; only
//                the SubWord operand changes (w3 forward, n3^n2 inverse).
//  Ports       : Inverse - 1 = inverse step, 0 = forward step
//                Rcon    - round constant (rcon[i+1] fwd, rcon[i] inv)
//                Key_in  - current round key
//                Key_out - next (fwd) or previous (inv) round key
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_key_pkg::*;
(
    input  logic                      Inverse,
    input  logic [7:0]                Rcon,
    input  logic [AES_BLOCK_SIZE-1:0] Key_in,
    output logic [AES_BLOCK_SIZE-1:0] Key_out
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_p3;
    logic [31:0] w_sub_in;
    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_t;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;

    assign {w_w0, w_w1, w_w2, w_w3} = Key_in;

    // In the inverse direction the previous key's last word is n3^n2.
    assign w_p3     = w_w3 ^ w_w2;
    assign w_sub_in = Inverse ? w_p3 : w_w3;
    assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[8*gi +: 8] = sbox(w_rot[8*gi +: 8]);
        end
    endgenerate

    assign w_t = w_sub ^ {Rcon, 24'h000000};

    assign w_f0 = w_w0 ^ w_t;
    assign w_f1 = w_f0 ^ w_w1;
    assign w_f2 = w_f1 ^ w_w2;
    assign w_f3 = w_f2 ^ w_w3;

    assign Key_out = Inverse ? {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_p3}
                             : {w_f0, w_f1, w_f2, w_f3};

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_key_schedule
//  Description : Iterative AES-128 round-key generator holding a single
//                128-bit key register. Encrypt walks rounds 0..10; decrypt
//                first expands forward to round 10 (PRECOMP), then walks
//                back down to round 0 with the inverse step.
//  Ports       : Clk, Rst_n (async, active low)
//                Start, Encrypt, Key   - schedule request, sampled in IDLE
//                Next                  - consumer took Round_key, advance
//                Round_key, Round_idx  - current key and its round number
//                Round_key_valid, Busy - status
//                Done                  - 1-cycle pulse after last key
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_schedule
    import aes_key_pkg::*;
#(
    parameter int NR = AES_NR   // AES-128 only
)(
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      Start,
    input  logic                      Encrypt,
    input  logic [AES_BLOCK_SIZE-1:0] Key,
    input  logic                      Next,
    output logic [AES_BLOCK_SIZE-1:0] Round_key,
    output logic [3:0]                Round_idx,
    output logic                      Round_key_valid,
    output logic                      Busy,
    output logic                      Done
);

    localparam logic [3:0] c_last_idx = 4'(NR);

    ks_state_t                 r_state;
    logic [AES_BLOCK_SIZE-1:0] r_key;
    logic [3:0]                r_idx;
    logic                      r_encrypt;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_inverse;
    logic [7:0]                w_rcon;
    logic [AES_BLOCK_SIZE-1:0] w_next_key;

    // PRECOMP always steps forward; OUTPUT steps in the latched direction.
    assign w_inverse = (r_state == KS_OUTPUT) && !r_encrypt;
    assign w_rcon    = w_inverse ? rcon_lookup(r_idx) : rcon_lookup(r_idx + 4'd1);

    aes_key_step u_step (
        .Inverse (w_inverse),
        .Rcon    (w_rcon),
        .Key_in  (r_key),
        .Key_out (w_next_key)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= KS_IDLE;
            r_key     <= '0;
            r_idx     <= 4'd0;
            r_encrypt <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                KS_IDLE: begin
                    if (Start) begin
                        r_key     <= Key;
                        r_idx     <= 4'd0;
                        r_encrypt <= Encrypt;
                        r_busy    <= 1'b1;
                        if (Encrypt) begin
                            r_state <= KS_OUTPUT;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= KS_PRECOMP;
                        end
                    end
                end
                KS_PRECOMP: begin
                    r_key <= w_next_key;
                    r_idx <= r_idx + 4'd1;
                    // This step produces the last round key.
                    if (r_idx == c_last_idx - 4'd1) begin
                        r_state <= KS_OUTPUT;
                        r_valid <= 1'b1;
                    end
                end
                KS_OUTPUT: begin
                    if (Next) begin
                        if (r_idx == (r_encrypt ? c_last_idx : 4'd0)) begin
                            // Key register keeps its last value on exit.
                            r_state <= KS_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_key <= w_next_key;
                            r_idx <= r_encrypt ? (r_idx + 4'd1) : (r_idx - 4'd1);
                        end
                    end
                end
                default: begin
                    r_state <= KS_IDLE;
                end
            endcase
        end
    end

    assign Round_key       = r_key;
    assign Round_idx       = r_idx;
    assign Round_key_valid = r_valid;
    assign Busy            = r_busy;
    assign Done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_key_schedule
//  Description : Self-checking bench for aes_inv_key_schedule. Known-answer
//                vectors plus an independent key-expansion model whose S-box
//                is derived from GF(2^8) inversion and the affine map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_schedule;

    localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_fips_rk1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_fips_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Start = 1'b0;
    logic         Encrypt = 1'b0;
    logic [127:0] Key = '0;
    logic         Next = 1'b0;
    logic [127:0] Round_key;
    logic [3:0]   Round_idx;
    logic         Round_key_valid;
    logic         Busy;
    logic         Done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] ref_rk   [0:10];

    aes_inv_key_schedule #(.NR(10)) u_dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .Start           (Start),
        .Encrypt         (Encrypt),
        .Key             (Key),
        .Next            (Next),
        .Round_key       (Round_key),
        .Round_idx       (Round_idx),
        .Round_key_valid (Round_key_valid),
        .Busy            (Busy),
        .Done            (Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_rcon(input int i);
        case (i)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] a;
        for (int v = 0; v < 256; v++) begin
            a   = 8'(v);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, a);   // a^254 = a^-1
            sbox_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic compute_ref(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {tb_rcon(i/4), 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full schedule. Called at #1 after a rising edge; returns at #1 after
    // the edge that took the final Next (Done cycle) unless settle is set.
    task automatic run_schedule(input logic [127:0] key, input logic enc,
                                input int max_stall, input bit poke, input bit settle);
        int cnt;
        int e;
        int s;
        compute_ref(key);
        Start = 1'b1; Key = key; Encrypt = enc; Next = 1'b0;
        tick();
        Start = 1'b0; Key = ~key; Encrypt = ~enc;
        check("busy_after_start", Busy, 1);
        check("done_after_start", Done, 0);
        cnt = 0;
        while (!Round_key_valid && cnt < 20) begin
            Next = 1'b1;   // ignored outside OUTPUT
            if (poke && cnt == 3) begin
                Start = 1'b1; Key = key ^ {4{32'hdeadbeef}}; Encrypt = 1'b1;
            end else begin
                Start = 1'b0;
            end
            tick();
            cnt++;
        end
        Start = 1'b0; Next = 1'b0;
        check("precomp_len", cnt, enc ? 0 : 10);
        for (int k = 0; k < 11; k++) begin
            e = enc ? k : 10 - k;
            check($sformatf("valid_r%0d", e), Round_key_valid, 1);
            check($sformatf("idx_r%0d", e), Round_idx, e);
            check($sformatf("key_r%0d", e), Round_key, ref_rk[e]);
            check($sformatf("busy_r%0d", e), Busy, 1);
            if (key == c_fips_key && e == 0)  check("kat_rk0", Round_key, c_fips_key);
            if (key == c_fips_key && e == 1)  check("kat_rk1", Round_key, c_fips_rk1);
            if (key == c_fips_key && e == 10) check("kat_rk10", Round_key, c_fips_rk10);
            s = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            for (int j = 0; j < s; j++) begin
                Next = 1'b0;
                tick();
                check($sformatf("stall_key_r%0d", e), Round_key, ref_rk[e]);
                check($sformatf("stall_idx_r%0d", e), Round_idx, e);
            end
            if (poke && k == 4) begin
                Start = 1'b1; Key = ~key; Encrypt = ~enc; Next = 1'b0;
                tick();
                Start = 1'b0;
                check("poke_key", Round_key, ref_rk[e]);
                check("poke_idx", Round_idx, e);
            end
            Next = 1'b1;
            tick();
            Next = 1'b0;
        end
        check("done_pulse", Done, 1);
        check("done_valid", Round_key_valid, 0);
        check("done_busy", Busy, 0);
        check("done_hold", Round_key, ref_rk[enc ? 10 : 0]);
        if (settle) begin
            tick();
            check("done_clear", Done, 0);
        end
    endtask

    initial begin
        int cnt;
        build_sbox();

        // Reset state, then Next in IDLE has no effect.
        Rst_n = 1'b0;
        tick(); tick();
        check("rst_key", Round_key, 0);
        check("rst_idx", Round_idx, 0);
        check("rst_valid", Round_key_valid, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Rst_n = 1'b1;
        Next  = 1'b1;
        tick(); tick();
        Next  = 1'b0;
        check("idle_next_valid", Round_key_valid, 0);
        check("idle_next_busy", Busy, 0);
        check("idle_next_idx", Round_idx, 0);

        // Known answers, Next held high.
        run_schedule(c_fips_key, 1'b1, 0, 1'b0, 1'b1);
        run_schedule(c_fips_key, 1'b0, 0, 1'b0, 1'b1);

        // Random stalls and ignored Start pulses.
        run_schedule(c_fips_key, 1'b1, 5, 1'b0, 1'b1);
        run_schedule(c_fips_key, 1'b0, 5, 1'b0, 1'b1);
        run_schedule(c_fips_key, 1'b0, 2, 1'b1, 1'b1);
        run_schedule(c_fips_key, 1'b1, 2, 1'b1, 1'b1);

        // Reset in the middle of a decrypt schedule at round 6.
        Start = 1'b1; Key = c_fips_key; Encrypt = 1'b0;
        tick();
        Start = 1'b0;
        cnt = 0;
        while (!Round_key_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("mid_rst_precomp", cnt, 10);
        for (int k = 0; k < 4; k++) begin
            Next = 1'b1;
            tick();
        end
        Next = 1'b0;
        check("mid_rst_idx6", Round_idx, 6);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_key", Round_key, 0);
        check("mid_rst_idx", Round_idx, 0);
        check("mid_rst_valid", Round_key_valid, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_done", Done, 0);
        tick();
        Rst_n = 1'b1;
        run_schedule(c_fips_key, 1'b1, 0, 1'b0, 1'b1);

        // Back-to-back random keys, Start issued in the Done cycle.
        for (int i = 0; i < 100; i++)
            run_schedule({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++)
            run_schedule({$urandom, $urandom, $urandom, $urandom}, 1'b0, 2, 1'b0, i == 99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Iterative AES-128 round-key generator that supplies one 128-bit round key per step to an iterative round datapath, in either direction. For encryption it walks forward from round 0 to round 10. For decryption it first expands forward to round 10, then walks backward with the inverse key-expansion step down to round 0. It sits beside the combined encrypt/decrypt round port and feeds its `Key` input. It replaces a stored 11-entry key table with one 128-bit register.

## Interface
- `NR`, 10: number of rounds (AES-128 only; other values unsupported).
- `Clk` input 1: single clock, rising edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `Start` input 1: one-cycle request to begin a schedule; sampled only in IDLE.
- `Encrypt` input 1: direction, sampled with `Start` (1 = forward, 0 = reverse).
- `Key` input `AES_BLOCK_SIZE`: cipher key, sampled with `Start`. `Key[127:120]` is byte 0.
- `Next` input 1: consumer has used the current `Round_key`; advance. Ignored unless `Round_key_valid`.
- `Round_key` output `AES_BLOCK_SIZE`: current round key.
- `Round_idx` output 4: round number of `Round_key`, in the range 0..10.
- `Round_key_valid` output 1: `Round_key` and `Round_idx` are meaningful.
- `Busy` output 1: high from the accepted `Start` until return to IDLE.
- `Done` output 1: one-cycle pulse when the final key has been consumed.

## Operation
- FSM states: IDLE, PRECOMP, OUTPUT.
- IDLE
  - `Start`=1 loads `Key` into the key register, sets `Round_idx`=0 and latches `Encrypt`.
  - If `Encrypt`=1: go to OUTPUT.
  - If `Encrypt`=0: go to PRECOMP.
- PRECOMP
  - Performs one forward step per cycle, incrementing `Round_idx`.
  - After the step that yields round 10, go to OUTPUT.
  - `Round_key_valid`=0 throughout.
- OUTPUT
  - `Round_key_valid`=1.
  - On `Next`, forward direction: if `Round_idx`=10, go to IDLE and pulse `Done`. Otherwise apply the forward step and increment `Round_idx`.
  - On `Next`, reverse direction: if `Round_idx`=0, go to IDLE and pulse `Done`. Otherwise apply the inverse step and decrement `Round_idx`.
- Forward step, words w0..w3 of the current key (w0 = `Key[127:96]`):
  - t = SubWord(RotWord(w3)) ^ {rcon[i+1], 24'h0}
  - n0 = w0^t, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3
  - i is the current `Round_idx`.
- Inverse step, current key n0..n3 at round i:
  - p3 = n3^n2, p2 = n2^n1, p1 = n1^n0
  - p0 = n0 ^ SubWord(RotWord(p3)) ^ {rcon[i], 24'h0}
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Indexed from the table, not generated by xtime.
- `Start` while `Busy` is ignored; the latched direction and key are unchanged.
- `Next` in IDLE or PRECOMP is ignored.
- `Key` and `Encrypt` may change freely after `Start` is accepted.
- Reset, including mid-schedule: state IDLE, and every output is 0 (`Round_key`, `Round_idx`, `Round_key_valid`, `Busy`, `Done`).
- On exit to IDLE, `Round_key` holds its last value. `Round_key_valid`=0.

## Timing
- `Start` at edge 0, encrypt: `Round_key_valid`=1 with `Round_idx`=0 after edge 0 (cycle 1).
- `Start` at edge 0, decrypt: 10 PRECOMP cycles, then `Round_key_valid`=1 with `Round_idx`=10 in cycle 11.
- `Next` sampled high at edge k: the new key is visible after edge k, so the consumer can take one key per cycle.
- Final `Next` at edge k: after edge k, `Done`=1 for exactly one cycle, `Round_key_valid`=0 and `Busy`=0.
- A new `Start` is accepted in the cycle `Done` is high, since the state is already IDLE.
- `Busy`=1 from after the `Start` edge through the final `Next` edge.
- Full encrypt schedule with `Next` held high: 11 valid cycles. Full decrypt schedule: 21 cycles from `Start`.

## Structure
- Package `aes_key_pkg`:
  - `AES_NR` = 10
  - rcon table `logic [7:0] [1:10]`
  - FSM state enum `{KS_IDLE, KS_PRECOMP, KS_OUTPUT}`
  - Reuses `AES_BLOCK_SIZE` from `aes_defines.svh`.
- Sub-module `aes_key_step`: combinational, ports `Inverse`, `Rcon[7:0]`, `Key_in`, `Key_out`.
  - Shares one set of four forward S-boxes between directions.
  - The SubWord operand is w3 when forward and p3 when inverse.
- The top level contains the FSM, the key register, the round counter and the direction flag.

## Test plan
- Encrypt, key `2b7e151628aed2a6abf7158809cf4f3c`, `Next` held high → idx0 = key, idx1 = `a0fafe1788542cb123a339392a6c7605`, idx10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`, then `Done` pulse.
- Decrypt, same key → first valid in cycle 11 with idx10 = `d014f9a8…0ca6`, idx1 = `a0fafe17…7605`, idx0 = `2b7e1516…4f3c`, then `Done`.
- Random `Next` stalls (0–5 cycles) in both directions → key sequence identical to the no-stall run; `Round_key` is stable while `Next`=0.
- `Start` pulsed in PRECOMP and in OUTPUT with a different key → ignored; the sequence completes on the original key.
- `Rst_n` asserted at decrypt round 6 → all outputs 0 immediately. A fresh encrypt `Start` then yields idx0 one cycle later.
- Back-to-back: `Start` in the `Done` cycle → the second schedule begins without a gap; compare against a reference model over 100 random keys in each direction.
